// File: rtl/mc_reinject_arb.sv
// Packet-atomic arbiter for the shared multicast decoder: input head-of-line flit vs re-injection FIFO.
// Remainders win by default; a saturating starvation counter forces input progress.
module mc_reinject_arb #(
  parameter int DOCW       = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_head,
  input  logic            in_tail,
  input  logic            in_um_type,
  input  logic [DOCW-1:0] in_doc,
  output logic            in_ready,
  input  logic            rf_valid,
  input  logic            rf_head,
  input  logic            rf_tail,
  input  logic [DOCW-1:0] rf_doc,
  input  logic            rf_afull,
  output logic            rf_ready,
  output logic            dec_valid,
  output logic            dec_sel,
  output logic            dec_um_type,
  output logic [DOCW-1:0] dec_doc,
  input  logic            dec_ready,
  output logic            err_proto
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK_IN, S_LOCK_RF} state_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       r_hold, w_hold_nxt;
  logic       r_hold_sel, w_hold_sel_nxt;
  logic       r_err, w_err_nxt;
  logic       w_rf_e, w_in_e, w_in_wait, w_pick_in, w_xfer, w_tail;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    w_rf_e    = rf_valid & rf_head;
    w_in_e    = in_valid & in_head & ~(in_um_type & rf_afull);
    w_in_wait = in_valid & in_head;
    w_pick_in = w_in_e & (~w_rf_e | (r_starve >= LP_STARVE));

    dec_valid = 1'b0;
    dec_sel   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A head offered but stalled keeps its grant until it transfers.
        if (r_hold) begin
          dec_sel   = r_hold_sel;
          dec_valid = r_hold_sel ? w_rf_e : w_in_wait;
        end else begin
          dec_sel   = w_rf_e & ~w_pick_in;
          dec_valid = w_in_e | w_rf_e;
        end
      end
      S_LOCK_IN: dec_valid = in_valid;
      S_LOCK_RF: begin
        dec_sel   = 1'b1;
        dec_valid = rf_valid;
      end
      default: ;
    endcase

    dec_um_type = dec_sel | in_um_type;
    dec_doc     = dec_sel ? rf_doc : in_doc;
    w_xfer      = dec_valid & dec_ready;
    in_ready    = w_xfer & ~dec_sel;
    rf_ready    = w_xfer & dec_sel;
    w_tail      = dec_sel ? rf_tail : in_tail;

    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve;
    w_hold_nxt     = r_hold;
    w_hold_sel_nxt = r_hold_sel;
    w_err_nxt      = 1'b0;
    if (r_state == S_IDLE) begin
      w_err_nxt      = (in_valid & ~in_head) | (rf_valid & ~rf_head);
      w_hold_nxt     = dec_valid & ~dec_ready;
      w_hold_sel_nxt = dec_sel;
      if (w_xfer) begin
        if (!w_tail) w_state_nxt = dec_sel ? S_LOCK_RF : S_LOCK_IN;
        if (!dec_sel)       w_starve_nxt = 4'd0;
        else if (w_in_wait) w_starve_nxt = sat_inc4(r_starve);
      end
    end else if (w_xfer && w_tail) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_starve <= 4'd0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_hold   <= w_hold_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Only meaningful while r_hold is set, so it needs no reset.
  always_ff @(posedge clk) begin
    r_hold_sel <= w_hold_sel_nxt;
  end

  assign err_proto = r_err;

endmodule

// File: tb/tb_mc_reinject_arb.sv
// Directed scoreboard bench for mc_reinject_arb: sources are flit queues, expected
// decoder transfers are queued in the order the arbitration rules dictate.
module tb_mc_reinject_arb;

  localparam int DOCW = 16;

  typedef struct packed {
    logic            head;
    logic            tail;
    logic            um;
    logic [DOCW-1:0] doc;
  } flit_t;

  typedef struct packed {
    logic            sel;
    logic            um;
    logic [DOCW-1:0] doc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_head, in_tail, in_um_type;
  logic [DOCW-1:0] in_doc;
  logic            in_ready;
  logic            rf_valid, rf_head, rf_tail, rf_afull;
  logic [DOCW-1:0] rf_doc;
  logic            rf_ready;
  logic            dec_valid, dec_sel, dec_um_type, dec_ready, err_proto;
  logic [DOCW-1:0] dec_doc;

  mc_reinject_arb #(.DOCW(DOCW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail), .in_um_type(in_um_type),
    .in_doc(in_doc), .in_ready(in_ready),
    .rf_valid(rf_valid), .rf_head(rf_head), .rf_tail(rf_tail), .rf_doc(rf_doc),
    .rf_afull(rf_afull), .rf_ready(rf_ready),
    .dec_valid(dec_valid), .dec_sel(dec_sel), .dec_um_type(dec_um_type), .dec_doc(dec_doc),
    .dec_ready(dec_ready), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  flit_t in_q[$];
  flit_t rf_q[$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  chk_en = 1'b0;
  logic  manual = 1'b0;
  logic  exp_err = 1'b0;
  logic  hold_chk = 1'b0;
  logic [DOCW-1:0] hold_doc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    flit_t f;
    if (manual) return;
    if (in_q.size() > 0) begin
      f = in_q[0];
      in_valid = 1'b1; in_head = f.head; in_tail = f.tail; in_um_type = f.um; in_doc = f.doc;
    end else begin
      in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; in_um_type = 1'b0; in_doc = '0;
    end
    if (rf_q.size() > 0) begin
      f = rf_q[0];
      rf_valid = 1'b1; rf_head = f.head; rf_tail = f.tail; rf_doc = f.doc;
    end else begin
      rf_valid = 1'b0; rf_head = 1'b0; rf_tail = 1'b0; rf_doc = '0;
    end
  endtask

  task automatic cycle();
    logic xi, xr;
    exp_t e;
    @(negedge clk);
    xi = in_ready;
    xr = rf_ready;
    if (chk_en) begin
      chk("err_proto", {31'd0, err_proto}, {31'd0, exp_err});
      if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
        chk("xfer_expected", sb.size(), (sb.size() > 0) ? sb.size() : 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("dec_sel", {31'd0, dec_sel}, {31'd0, e.sel});
          chk("dec_um_type", {31'd0, dec_um_type}, {31'd0, e.um});
          chk("dec_doc", {16'd0, dec_doc}, {16'd0, e.doc});
          chk("in_ready_xfer", {31'd0, in_ready}, {31'd0, ~e.sel});
          chk("rf_ready_xfer", {31'd0, rf_ready}, {31'd0, e.sel});
        end
      end else begin
        chk("in_ready_noxfer", {31'd0, in_ready}, 32'd0);
        chk("rf_ready_noxfer", {31'd0, rf_ready}, 32'd0);
      end
      if (hold_chk) begin
        chk("hold_valid", {31'd0, dec_valid}, 32'd1);
        chk("hold_sel", {31'd0, dec_sel}, 32'd0);
        chk("hold_doc", {16'd0, dec_doc}, {16'd0, hold_doc});
      end
    end
    @(posedge clk);
    #1;
    if (!manual) begin
      if (xi === 1'b1 && in_q.size() > 0) in_q.delete(0);
      if (xr === 1'b1 && rf_q.size() > 0) rf_q.delete(0);
    end
    drive();
  endtask

  task automatic run_till_done(input string tag, input int max);
    int k = 0;
    while ((sb.size() > 0 || in_q.size() > 0 || rf_q.size() > 0) && k < max) begin
      cycle();
      k++;
    end
    chk({tag, "_drained"}, sb.size() + in_q.size() + rf_q.size(), 0);
  endtask

  function automatic flit_t mk(input logic h, input logic t, input logic u, input logic [DOCW-1:0] d);
    flit_t f;
    f.head = h; f.tail = t; f.um = u; f.doc = d;
    return f;
  endfunction

  function automatic exp_t ex(input logic s, input logic u, input logic [DOCW-1:0] d);
    exp_t e;
    e.sel = s; e.um = u; e.doc = d;
    return e;
  endfunction

  initial begin
    rst = 1'b1; rf_afull = 1'b0; dec_ready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state with no traffic
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rf_ready", {31'd0, rf_ready}, 32'd0);
    chk("rst_err_proto", {31'd0, err_proto}, 32'd0);
    chk("rst_dec_sel", {31'd0, dec_sel}, 32'd0);
    dec_ready = 1'b1;
    cycle();

    // Remainder packet beats a waiting unicast, then the input follows with no bubble
    in_q.push_back(mk(1, 1, 0, 16'h0055));
    rf_q.push_back(mk(1, 0, 0, 16'h00F0));
    rf_q.push_back(mk(0, 0, 0, 16'h00F0));
    rf_q.push_back(mk(0, 1, 0, 16'h00F0));
    sb.push_back(ex(1, 1, 16'h00F0));
    sb.push_back(ex(1, 1, 16'h00F0));
    sb.push_back(ex(1, 1, 16'h00F0));
    sb.push_back(ex(0, 0, 16'h0055));
    drive();
    repeat (4) cycle();
    chk("t2_exact_latency", sb.size() + in_q.size() + rf_q.size(), 0);

    // Starvation: four remainder packets, then input; counter cleared so four more before the next input
    for (int i = 0; i < 9; i++) rf_q.push_back(mk(1, 1, 0, 16'h0100 + 16'(i)));
    for (int j = 0; j < 2; j++) in_q.push_back(mk(1, 1, 0, 16'h0200 + 16'(j)));
    for (int i = 0; i < 4; i++) sb.push_back(ex(1, 1, 16'h0100 + 16'(i)));
    sb.push_back(ex(0, 0, 16'h0200));
    for (int i = 4; i < 8; i++) sb.push_back(ex(1, 1, 16'h0100 + 16'(i)));
    sb.push_back(ex(0, 0, 16'h0201));
    sb.push_back(ex(1, 1, 16'h0108));
    drive();
    run_till_done("t3", 30);

    // Multicast head gated by rf_afull; unicast is not
    rf_afull = 1'b1;
    in_q.push_back(mk(1, 1, 1, 16'h8001));
    drive();
    repeat (3) cycle();
    chk("t4_mc_blocked_valid", {31'd0, dec_valid}, 32'd0);
    chk("t4_mc_blocked_pending", in_q.size(), 1);
    rf_afull = 1'b0;
    sb.push_back(ex(0, 1, 16'h8001));
    cycle();
    chk("t4_mc_released", sb.size() + in_q.size(), 0);
    rf_afull = 1'b1;
    in_q.push_back(mk(1, 1, 0, 16'h1234));
    sb.push_back(ex(0, 0, 16'h1234));
    drive();
    cycle();
    chk("t4_uc_immediate", sb.size() + in_q.size(), 0);
    rf_afull = 1'b0;

    // Locked input packet stalled on flit 2: stable outputs, no remainder interleave
    for (int i = 0; i < 4; i++) begin
      in_q.push_back(mk(i == 0, i == 3, 0, 16'h00A0 + 16'(i)));
      sb.push_back(ex(0, 0, 16'h00A0 + 16'(i)));
    end
    sb.push_back(ex(1, 1, 16'h00BB));
    drive();
    cycle();
    dec_ready = 1'b0;
    rf_q.push_back(mk(1, 1, 0, 16'h00BB));
    drive();
    hold_chk = 1'b1;
    hold_doc = 16'h00A1;
    repeat (3) cycle();
    hold_chk = 1'b0;
    dec_ready = 1'b1;
    run_till_done("t5", 10);

    // Body flit in IDLE: one-cycle err_proto pulse, never granted
    manual = 1'b1;
    in_valid = 1'b1; in_head = 1'b0; in_tail = 1'b0; in_um_type = 1'b0; in_doc = 16'h0EEE;
    rf_valid = 1'b0;
    cycle();
    in_valid = 1'b0;
    exp_err = 1'b1;
    cycle();
    exp_err = 1'b0;
    cycle();
    manual = 1'b0;

    // Reset while locked to the re_fifo drops ownership
    rf_q.push_back(mk(1, 0, 0, 16'h00C0));
    rf_q.push_back(mk(0, 0, 0, 16'h00C1));
    rf_q.push_back(mk(0, 1, 0, 16'h00C2));
    sb.push_back(ex(1, 1, 16'h00C0));
    drive();
    cycle();
    dec_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    dec_ready = 1'b1;
    in_q.push_back(mk(1, 1, 0, 16'h00D0));
    sb.push_back(ex(0, 0, 16'h00D0));
    drive();
    cycle();
    chk("t6_idle_after_rst", sb.size() + in_q.size(), 0);
    rf_q.delete();
    drive();
    exp_err = 1'b1;
    cycle();
    exp_err = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
